// File: rtl/mat_row_sequencer_pkg.sv
// ============================================================================
// Module   : mat_row_sequencer_pkg
// Brief    : Shared types for the matrix-unit issue path (dispatch packet,
//            row beat struct, matrix type codes).
// Revision : 1.0
// ============================================================================
`default_nettype none

package mat_row_sequencer_pkg;

   localparam int MAT_ROW_W    = 4;
   localparam int M_INSTR_BITS = 4;
   localparam int M_TYPE_NONE  = 0;

   typedef struct packed {
      logic [15:0]             uuid;
      logic [1:0]              m_type;
      logic [MAT_ROW_W-1:0]    m_row_size;
      logic [M_INSTR_BITS-1:0] m_instr_id;
      logic [M_INSTR_BITS-1:0] m_instr_cnt;
      logic [31:0]             payload;
   } data_t;

   // Execute lane consumes the packet plus its row tags as one word.
   typedef struct packed {
      data_t                data;
      logic [MAT_ROW_W-1:0] row_idx;
      logic                 row_last;
      logic                 instr_last;
   } mat_row_t;

endpackage

`default_nettype wire

// File: rtl/mat_row_sequencer_if.sv
// ============================================================================
// Module   : mat_row_sequencer_if
// Brief    : Dispatch valid/ready handshake carrying one instruction packet.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mat_row_sequencer_if;
   import mat_row_sequencer_pkg::*;

   logic  valid;
   logic  ready;
   data_t data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

`default_nettype wire

// File: rtl/mat_row_sequencer.sv
// ============================================================================
// Module   : mat_row_sequencer
// Brief    : Holds one dispatched packet and replays it as one row beat per
//            cycle, tagging row index and last-row / last-instruction flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mat_row_sequencer #(
   parameter string INSTANCE_ID = "",
   parameter int    MAX_ROWS    = 16,
   parameter int    M_TYPE_NONE = 0,
   localparam int   ROW_W       = $clog2(MAX_ROWS)
) (
   input  wire logic                       clk,
   input  wire logic                       reset,
   mat_row_sequencer_if.slave              dispatch_if,
   output logic                            row_valid,
   input  wire logic                       row_ready,
   output mat_row_sequencer_pkg::data_t    row_data,
   output logic [ROW_W-1:0]                row_idx,
   output logic                            row_last,
   output logic                            instr_last,
   output logic                            busy
);
   import mat_row_sequencer_pkg::*;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t                  r_state;
   data_t                   r_pkt;
   logic [ROW_W-1:0]        r_row_idx;
   logic [ROW_W-1:0]        r_rows_m1;

   logic                    w_row_last;
   logic                    w_fire;
   logic                    w_accept;
   logic                    w_is_final_instr;
   logic [ROW_W-1:0]        w_load_rows_m1;
   logic [M_INSTR_BITS-1:0] w_instr_tgt;

   always_comb begin
      w_row_last        = (r_state == S_ISSUE) && (r_row_idx == r_rows_m1);
      w_fire            = (r_state == S_ISSUE) && row_ready;
      dispatch_if.ready = (r_state == S_IDLE) || (w_fire && w_row_last);
      w_accept          = dispatch_if.valid && dispatch_if.ready;

      // Row count is clamped to the ceiling; non-matrix packets are one beat.
      w_load_rows_m1 = '0;
      if (int'(dispatch_if.data.m_type) != M_TYPE_NONE) begin
         if (int'(dispatch_if.data.m_row_size) > MAX_ROWS - 1)
            w_load_rows_m1 = ROW_W'(MAX_ROWS - 1);
         else
            w_load_rows_m1 = ROW_W'(dispatch_if.data.m_row_size);
      end

      // An instruction count of zero behaves as a count of one.
      w_instr_tgt = (r_pkt.m_instr_cnt == '0) ? '0
                  : r_pkt.m_instr_cnt - M_INSTR_BITS'(1);
      w_is_final_instr = (int'(r_pkt.m_type) == M_TYPE_NONE)
                      || (r_pkt.m_instr_id == w_instr_tgt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pkt     <= '0;
         r_row_idx <= '0;
         r_rows_m1 <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_pkt     <= dispatch_if.data;
                  r_row_idx <= '0;
                  r_rows_m1 <= w_load_rows_m1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_fire) begin
                  if (!w_row_last) begin
                     r_row_idx <= r_row_idx + ROW_W'(1);
                  end else if (w_accept) begin
                     r_pkt     <= dispatch_if.data;
                     r_row_idx <= '0;
                     r_rows_m1 <= w_load_rows_m1;
                  end else begin
                     r_state   <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign row_valid  = (r_state == S_ISSUE);
   assign busy       = (r_state == S_ISSUE);
   assign row_data   = r_pkt;
   assign row_idx    = r_row_idx;
   assign row_last   = w_row_last;
   assign instr_last = w_row_last && w_is_final_instr;

endmodule

`default_nettype wire

// File: tb/tb_mat_row_sequencer.sv
// ============================================================================
// Module   : tb_mat_row_sequencer
// Brief    : Randomized and directed bench for mat_row_sequencer against a
//            beat-queue reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mat_row_sequencer;
   import mat_row_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mat_row_sequencer_if d16 ();
   mat_row_sequencer_if d8 ();

   logic       rv16, rr16, rl16, il16, busy16;
   data_t      rd16;
   logic [3:0] ri16;
   logic       rv8, rr8, rl8, il8, busy8;
   data_t      rd8;
   logic [2:0] ri8;

   mat_row_sequencer #(.INSTANCE_ID("u16"), .MAX_ROWS(16), .M_TYPE_NONE(0)) dut (
      .clk(clk), .reset(reset), .dispatch_if(d16),
      .row_valid(rv16), .row_ready(rr16), .row_data(rd16), .row_idx(ri16),
      .row_last(rl16), .instr_last(il16), .busy(busy16));

   mat_row_sequencer #(.INSTANCE_ID("u8"), .MAX_ROWS(8), .M_TYPE_NONE(0)) dut8 (
      .clk(clk), .reset(reset), .dispatch_if(d8),
      .row_valid(rv8), .row_ready(rr8), .row_data(rd8), .row_idx(ri8),
      .row_last(rl8), .instr_last(il8), .busy(busy8));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference rules: beat count and final-instruction flag of a packet.
   function automatic int rows_of(input data_t d, input int maxr);
      if (d.m_type == 2'd0) return 1;
      return ((int'(d.m_row_size) > maxr - 1) ? maxr - 1 : int'(d.m_row_size)) + 1;
   endfunction

   function automatic bit is_final_instr(input data_t d);
      int tgt;
      tgt = (d.m_instr_cnt == 0) ? 0 : int'(d.m_instr_cnt) - 1;
      return (d.m_type == 2'd0) || (int'(d.m_instr_id) == tgt);
   endfunction

   function automatic data_t mk(input int uuid, input int ty, input int rs,
                                input int id, input int cnt);
      data_t d;
      d.uuid        = 16'(uuid);
      d.m_type      = 2'(ty);
      d.m_row_size  = 4'(rs);
      d.m_instr_id  = 4'(id);
      d.m_instr_cnt = 4'(cnt);
      d.payload     = $urandom;
      return d;
   endfunction

   typedef struct {
      data_t d;
      int    idx;
      bit    last;
      bit    ilast;
   } beat_t;

   beat_t q[$];

   function automatic void push_pkt(input data_t d);
      int n;
      n = rows_of(d, 16);
      for (int r = 0; r < n; r++) begin
         beat_t b;
         b.d     = d;
         b.idx   = r;
         b.last  = (r == n - 1);
         b.ilast = b.last && is_final_instr(d);
         q.push_back(b);
      end
   endfunction

   // Model compare: expected beats are the queued rows of the held packet.
   always @(negedge clk) begin
      bit has;
      bit exp_ready;
      if (reset) begin
         q.delete();
      end else begin
         has       = (q.size() > 0);
         exp_ready = !has || (rr16 && q[0].last);
         chk("row_valid", rv16, has);
         chk("busy", busy16, has);
         chk("ready", d16.ready, exp_ready);
         if (has) begin
            chk("row_idx", ri16, q[0].idx);
            chk("row_last", rl16, q[0].last);
            chk("instr_last", il16, q[0].ilast);
            chk("row_data", rd16, q[0].d);
            if (rr16) void'(q.pop_front());
         end
         if (d16.valid && exp_ready) push_pkt(d16.data);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  n;
      bit  found;
      int  stall_idx [9];
      stall_idx = '{0, 1, 2, 2, 2, 2, 3, 4, 5};

      reset     = 1'b1;
      d16.valid = 1'b0;
      d16.data  = '0;
      rr16      = 1'b1;
      d8.valid  = 1'b0;
      d8.data   = '0;
      rr8       = 1'b1;

      // Pin the reference rules with hand-computed values.
      chk("pin_rows_rs15", rows_of(mk(0, 1, 15, 0, 0), 16), 16);
      chk("pin_rows_clamp8", rows_of(mk(0, 1, 15, 0, 0), 8), 8);
      chk("pin_rows_nonmat", rows_of(mk(0, 0, 7, 0, 0), 16), 1);
      chk("pin_final_cnt0", is_final_instr(mk(0, 1, 3, 0, 0)), 1);
      chk("pin_final_id1", is_final_instr(mk(0, 1, 3, 1, 3)), 0);

      repeat (3) cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_rv", rv16, 0);
      chk("reset_idx", ri16, 0);
      chk("reset_last", rl16, 0);
      chk("reset_ilast", il16, 0);
      chk("reset_ready", d16.ready, 1);
      chk("reset_data", rd16, 0);
      cyc();

      // Clamp: 16 requested rows on an 8-row instance.
      d8.data  = mk(5, 1, 15, 0, 1);
      d8.valid = 1'b1;
      cyc();
      d8.valid = 1'b0;
      n = 0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (rv8) begin
            n++;
            if (rl8) begin
               found = 1'b1;
               chk("m8_last_idx", ri8, 7);
            end
         end
         cyc();
      end
      chk("m8_found_last", found, 1);
      chk("m8_beats", n, 8);

      // Matrix packet of four rows, last instruction of two.
      d16.data  = mk(1, 1, 3, 1, 2);
      d16.valid = 1'b1;
      cyc();
      d16.valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk("m4_idx", ri16, b);
         chk("m4_last", rl16, b == 3);
         chk("m4_ilast", il16, b == 3);
         chk("m4_ready", d16.ready, b == 3);
         cyc();
      end

      // Non-matrix packet: single beat.
      d16.data  = mk(2, 0, 7, 3, 9);
      d16.valid = 1'b1;
      cyc();
      d16.valid = 1'b0;
      @(negedge clk);
      chk("nm_idx", ri16, 0);
      chk("nm_last", rl16, 1);
      chk("nm_ilast", il16, 1);
      cyc();
      @(negedge clk);
      chk("nm_done", rv16, 0);
      cyc();

      // Back-to-back two-row packets with no bubble.
      d16.data  = mk(10, 1, 1, 0, 1);
      d16.valid = 1'b1;
      cyc();
      d16.data  = mk(11, 1, 1, 0, 1);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk("b2b_valid", rv16, 1);
         chk("b2b_idx", ri16, b % 2);
         chk("b2b_uuid", rd16.uuid, (b < 2) ? 10 : 11);
         cyc();
         if (b == 1) d16.valid = 1'b0;
      end

      // Three stall cycles at row 2 of a six-row packet.
      d16.data  = mk(20, 2, 5, 0, 1);
      d16.valid = 1'b1;
      cyc();
      d16.valid = 1'b0;
      for (int c = 0; c < 9; c++) begin
         rr16 = !(c >= 2 && c <= 4);
         @(negedge clk);
         chk("stall_idx", ri16, stall_idx[c]);
         chk("stall_ready", d16.ready, c == 8);
         cyc();
      end
      rr16 = 1'b1;
      @(negedge clk);
      chk("stall_done", rv16, 0);
      cyc();

      // Reset pulse while at row 5 of a sixteen-row packet.
      d16.data  = mk(30, 1, 15, 0, 1);
      d16.valid = 1'b1;
      cyc();
      d16.valid = 1'b0;
      for (int c = 0; c < 5; c++) cyc();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_pre_idx", ri16, 5);
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_rv", rv16, 0);
      chk("rst_busy", busy16, 0);
      chk("rst_ready", d16.ready, 1);
      d16.data  = mk(31, 1, 2, 0, 1);
      d16.valid = 1'b1;
      cyc();
      d16.valid = 1'b0;
      @(negedge clk);
      chk("rst_new_idx", ri16, 0);
      chk("rst_new_uuid", rd16.uuid, 31);
      repeat (4) cyc();

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         d16.valid = ($urandom_range(0, 2) != 0);
         d16.data  = mk($urandom_range(0, 65535), $urandom_range(0, 3),
                        $urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 15));
         rr16      = ($urandom_range(0, 3) != 0);
         cyc();
      end
      reset     = 1'b0;
      d16.valid = 1'b0;
      rr16      = 1'b1;
      repeat (20) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
